// File: rtl/pc_pkg.sv
// pc_pkg: shared defaults and the decoded per-cycle PC operation for pc_unit.
package pc_pkg;
   localparam int DEF_ADDR_WIDTH = 24;
   localparam logic [DEF_ADDR_WIDTH-1:0] DEF_RESET_VECTOR = '0;
   typedef enum logic [2:0] {OP_KEEP, OP_INC, OP_LOAD, OP_CALL, OP_RET} pc_op_t;
endpackage

// File: rtl/pc_ras_stack.sv
// pc_ras_stack: saturating LIFO of return addresses; push ignored when full, pop ignored when empty.
module pc_ras_stack #(
   parameter int WIDTH = 24,
   parameter int DEPTH = 4,
   localparam int CW = $clog2(DEPTH + 1),
   localparam int IW = $clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] pushData,
   output logic [WIDTH-1:0] topData,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);
   logic [WIDTH-1:0] mem [DEPTH];
   assign full = count == CW'(DEPTH);
   assign empty = count == '0;
   assign topData = mem[IW'(count - CW'(1))];
   always_ff @(posedge clock) begin
      if (reset) count <= '0;
      else if (push && !full) count <= count + CW'(1);
      else if (pop && !empty) count <= count - CW'(1);
   end
   // contents need no reset; only the count defines validity
   always_ff @(posedge clock) begin
      if (!reset && push && !full) mem[IW'(count)] <= pushData;
   end
endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter with increment, branch, call/return via RAS, hold and sticky stack errors.
// The return-address stack and error flags exist only when PC_UNIT_RAS_EN is defined.
module pc_unit
   import pc_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int INC_STEP = 1,
   parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(DEF_RESET_VECTOR),
   parameter int RAS_DEPTH = 4
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           pc_hold,
   input  logic                           pc_inc_en,
   input  logic                           pc_load_en,
   input  logic                           pc_call_en,
   input  logic                           pc_ret_en,
   input  logic                           err_clr,
   input  logic [ADDR_WIDTH-1:0]          pc_data_in,
   output logic [ADDR_WIDTH-1:0]          pc_out,
   output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
   output logic                           ras_full,
   output logic                           ras_empty,
   output logic                           err_ovf,
   output logic                           err_unf
);
   pc_op_t op;
   logic [ADDR_WIDTH-1:0] pcInc, nextPc, rasTop;
   assign pcInc = pc_out + ADDR_WIDTH'(INC_STEP);
   always_comb op = pc_hold ? OP_KEEP : pc_load_en ? OP_LOAD : pc_ret_en ? OP_RET :
                    pc_call_en ? OP_CALL : pc_inc_en ? OP_INC : OP_KEEP;
`ifdef PC_UNIT_RAS_EN
   pc_ras_stack #(.WIDTH(ADDR_WIDTH), .DEPTH(RAS_DEPTH)) rasStack (
      .clock    (clock),
      .reset    (reset),
      .push     (op == OP_CALL),
      .pop      (op == OP_RET),
      .pushData (pcInc),
      .topData  (rasTop),
      .count    (ras_count),
      .full     (ras_full),
      .empty    (ras_empty)
   );
   // a new error in the same cycle as err_clr must win
   always_ff @(posedge clock) begin
      if (reset) begin
         err_ovf <= 1'b0;
         err_unf <= 1'b0;
      end else begin
         err_ovf <= (op == OP_CALL && ras_full) || (err_ovf && !err_clr);
         err_unf <= (op == OP_RET && ras_empty) || (err_unf && !err_clr);
      end
   end
`else
   logic unusedClr;
   assign unusedClr = err_clr;
   assign rasTop = pcInc;
   assign ras_count = '0;
   assign ras_full = 1'b0;
   assign ras_empty = 1'b1;
   assign err_ovf = 1'b0;
   assign err_unf = 1'b0;
`endif
   always_comb nextPc = (op == OP_LOAD || op == OP_CALL) ? pc_data_in :
                        op == OP_RET ? (ras_empty ? pcInc : rasTop) :
                        op == OP_INC ? pcInc : pc_out;
   always_ff @(posedge clock) pc_out <= reset ? RESET_VECTOR : nextPc;
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed and random stimulus for pc_unit against a queue-based reference model.
// Follows PC_UNIT_RAS_EN so the model matches whichever build is compiled.
module tb_pc_unit;
   localparam int AW = 24;
   localparam logic [AW-1:0] RV = 24'h000100;
   localparam int DEPTH = 4;
`ifdef PC_UNIT_RAS_EN
   localparam bit RAS_ON = 1'b1;
`else
   localparam bit RAS_ON = 1'b0;
`endif
   logic clock = 1'b0, reset, pc_hold, pc_inc_en, pc_load_en, pc_call_en, pc_ret_en, err_clr;
   logic [AW-1:0] pc_data_in, pc_out;
   logic [2:0] ras_count;
   logic ras_full, ras_empty, err_ovf, err_unf;
   int checks = 0, errors = 0;
   logic [AW-1:0] mPc;
   logic [AW-1:0] mStack[$];
   bit mOvf, mUnf;

   pc_unit #(.ADDR_WIDTH(AW), .INC_STEP(1), .RESET_VECTOR(RV), .RAS_DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset), .pc_hold(pc_hold), .pc_inc_en(pc_inc_en),
      .pc_load_en(pc_load_en), .pc_call_en(pc_call_en), .pc_ret_en(pc_ret_en),
      .err_clr(err_clr), .pc_data_in(pc_data_in), .pc_out(pc_out), .ras_count(ras_count),
      .ras_full(ras_full), .ras_empty(ras_empty), .err_ovf(err_ovf), .err_unf(err_unf)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // one clock with the given strobes, model update, then full output comparison
   task automatic step(input bit rst, input bit hold, input bit inc, input bit ld, input bit call,
                       input bit ret, input bit clr, input logic [AW-1:0] d);
      bit newOvf = 0, newUnf = 0;
      reset = rst; pc_hold = hold; pc_inc_en = inc; pc_load_en = ld;
      pc_call_en = call; pc_ret_en = ret; err_clr = clr; pc_data_in = d;
      @(posedge clock);
      if (rst) begin
         mPc = RV; mStack.delete(); mOvf = 0; mUnf = 0;
      end else begin
         if (!hold) begin
            if (ld) mPc = d;
            else if (ret) begin
               if (RAS_ON && mStack.size() > 0) mPc = mStack.pop_back();
               else begin mPc = mPc + 1; newUnf = RAS_ON; end
            end else if (call) begin
               if (RAS_ON && mStack.size() < DEPTH) mStack.push_back(mPc + 1);
               else newOvf = RAS_ON;
               mPc = d;
            end else if (inc) mPc = mPc + 1;
         end
         mOvf = newOvf || (mOvf && !clr);
         mUnf = newUnf || (mUnf && !clr);
      end
      #1;
      chk("pc_out", 32'(pc_out), 32'(mPc));
      chk("ras_count", 32'(ras_count), 32'(mStack.size()));
      chk("ras_empty", 32'(ras_empty), 32'(mStack.size() == 0));
      chk("ras_full", 32'(ras_full), 32'(mStack.size() == DEPTH));
      chk("err_ovf", 32'(err_ovf), 32'(mOvf));
      chk("err_unf", 32'(err_unf), 32'(mUnf));
   endtask

   initial begin
      mPc = '0; mOvf = 0; mUnf = 0;
      // reset held two cycles with inc requested
      step(1, 0, 1, 0, 0, 0, 0, '0);
      step(1, 0, 1, 0, 0, 0, 0, '0);
      chk("reset_pc", 32'(pc_out), 32'h100);
      // increment across the wrap point
      step(0, 0, 0, 1, 0, 0, 0, 24'hFFFFFE);
      step(0, 0, 1, 0, 0, 0, 0, '0);
      chk("inc_ff", 32'(pc_out), 32'hFFFFFF);
      step(0, 0, 1, 0, 0, 0, 0, '0);
      chk("inc_wrap", 32'(pc_out), 32'h0);
      step(0, 0, 1, 0, 0, 0, 0, '0);
      chk("inc_one", 32'(pc_out), 32'h1);
      // nested calls and returns
      step(0, 0, 0, 1, 0, 0, 0, 24'h000010);
      step(0, 0, 0, 0, 1, 0, 0, 24'h000200);
      step(0, 0, 0, 0, 1, 0, 0, 24'h000300);
      step(0, 0, 0, 0, 0, 1, 0, '0);
      chk("ret1", 32'(pc_out), RAS_ON ? 32'h201 : 32'h301);
      step(0, 0, 0, 0, 0, 1, 0, '0);
      chk("ret2", 32'(pc_out), RAS_ON ? 32'h11 : 32'h302);
      // overflow then underflow then clear
      for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 0, 0, AW'(24'h001000 + i * 16));
      chk("ovf_jump", 32'(pc_out), 32'h1040);
      chk("ovf_flag", 32'(err_ovf), 32'(RAS_ON));
      for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 1, 0, '0);
      chk("unf_flag", 32'(err_unf), 32'(RAS_ON));
      step(0, 0, 0, 0, 0, 0, 1, '0);
      // hold, simultaneous commands, reset during a call
      step(0, 1, 1, 1, 0, 0, 0, 24'h00ABCD);
      step(0, 0, 1, 1, 1, 0, 0, 24'h000777);
      chk("ld_call_inc", 32'(pc_out), 32'h777);
      step(0, 0, 0, 0, 1, 0, 0, 24'h000500);
      step(1, 0, 0, 0, 1, 0, 0, 24'h000600);
      chk("reset_mid_call", 32'(pc_out), 32'h100);
      // call then return
      step(0, 0, 0, 1, 0, 0, 0, 24'h000050);
      step(0, 0, 0, 0, 1, 0, 0, 24'h000400);
      step(0, 0, 0, 0, 0, 1, 0, '0);
      chk("call_ret", 32'(pc_out), RAS_ON ? 32'h51 : 32'h401);
      // error set racing err_clr
      step(0, 0, 0, 0, 0, 1, 1, '0);
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 49) == 0, $urandom_range(0, 7) == 0, 1'($urandom),
              $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 9) == 0, AW'($urandom));
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
